// File: rtl/sprite_pixel_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pixel_gen_if
// Purpose  : Request/result handshake bundle for the sprite pixel generator.
// Revision : 1.0
// ============================================================================
interface sprite_pixel_gen_if #(
    parameter int CW      = 6,
    parameter int COLOR_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         shape;
    logic [1:0]         rot;
    logic               ghost;
    logic [CW-1:0]      px;
    logic [CW-1:0]      py;
    logic               out_valid;
    logic               out_ready;
    logic [COLOR_W-1:0] color;
    logic               opaque;

    modport master (
        output in_valid, shape, rot, ghost, px, py, out_ready,
        input  in_ready, out_valid, color, opaque
    );

    modport slave (
        input  in_valid, shape, rot, ghost, px, py, out_ready,
        output in_ready, out_valid, color, opaque
    );
endinterface
`default_nettype wire

// File: rtl/sprite_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pixel_gen
// Purpose  : Two-stage pipelined tetromino pixel colourer with backpressure.
// Revision : 1.0
// ============================================================================
module sprite_pixel_gen #(
    parameter int TILE         = 16,
    parameter int BORDER       = 2,
    parameter int COLOR_W      = 3,
    parameter int BORDER_COLOR = 7,
    parameter int GHOST_COLOR  = 6,
    parameter int CW           = $clog2(4*TILE)
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sprite_pixel_gen_if.slave bus,
    output logic              err,
    output logic [15:0]       pix_count
);

    localparam int LOG_T = $clog2(TILE);
    localparam logic [LOG_T-1:0] c_border_lo = LOG_T'(BORDER);
    localparam logic [LOG_T-1:0] c_border_hi = LOG_T'(TILE - BORDER);

    // One clockwise quarter turn: new[r][c] = old[3-c][r]
    function automatic logic [15:0] rot_cw(input logic [15:0] m);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n[r*4+c] = m[(3-c)*4+r];
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] base_mask(input logic [2:0] s);
        logic [15:0] m;
        case (s)
            3'd0:    m = 16'h00F0;
            3'd1:    m = 16'h0066;
            3'd2:    m = 16'h0072;
            3'd3:    m = 16'h0036;
            3'd4:    m = 16'h0063;
            3'd5:    m = 16'h0071;
            3'd6:    m = 16'h0074;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    logic [15:0]        w_rot0;
    logic [15:0]        w_rot1;
    logic [15:0]        w_rot2;
    logic [15:0]        w_rot3;
    logic [15:0]        w_mask;
    logic [3:0]         w_cell;
    logic               w_occ;
    logic               w_s1_open;
    logic               w_s2_open;
    logic               w_accept;
    logic               w_border;
    logic [COLOR_W-1:0] w_color;
    logic               w_opaque;

    logic               r_s1_valid;
    logic               r_s1_occ;
    logic               r_s1_ghost;
    logic [COLOR_W-1:0] r_s1_fill;
    logic [LOG_T-1:0]   r_s1_ox;
    logic [LOG_T-1:0]   r_s1_oy;
    logic               r_s2_valid;
    logic [COLOR_W-1:0] r_color;
    logic               r_opaque;

    assign w_rot0 = base_mask(bus.shape);
    assign w_rot1 = rot_cw(w_rot0);
    assign w_rot2 = rot_cw(w_rot1);
    assign w_rot3 = rot_cw(w_rot2);

    always_comb begin
        w_mask = w_rot0;
        case (bus.rot)
            2'd0:    w_mask = w_rot0;
            2'd1:    w_mask = w_rot1;
            2'd2:    w_mask = w_rot2;
            default: w_mask = w_rot3;
        endcase
    end

    // Cell index is {row, col}, both taken from the coordinate bits above the tile offset
    assign w_cell = {bus.py[CW-1:LOG_T], bus.px[CW-1:LOG_T]};
    assign w_occ  = w_mask[w_cell];

    assign w_s2_open    = !r_s2_valid || bus.out_ready;
    assign w_s1_open    = !r_s1_valid || w_s2_open;
    assign w_accept     = bus.in_valid && w_s1_open;
    assign bus.in_ready = w_s1_open;

    assign w_border = (r_s1_ox < c_border_lo) || (r_s1_ox >= c_border_hi) ||
                      (r_s1_oy < c_border_lo) || (r_s1_oy >= c_border_hi);

    always_comb begin
        w_color  = '0;
        w_opaque = 1'b0;
        if (r_s1_occ) begin
            if (r_s1_ghost) begin
                if (w_border) begin
                    w_color  = COLOR_W'(GHOST_COLOR);
                    w_opaque = 1'b1;
                end
            end else begin
                w_opaque = 1'b1;
                w_color  = w_border ? COLOR_W'(BORDER_COLOR) : r_s1_fill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_occ   <= 1'b0;
            r_s1_ghost <= 1'b0;
            r_s1_fill  <= '0;
            r_s1_ox    <= '0;
            r_s1_oy    <= '0;
            r_s2_valid <= 1'b0;
            r_color    <= '0;
            r_opaque   <= 1'b0;
            err        <= 1'b0;
            pix_count  <= 16'd0;
        end else begin
            if (w_s1_open) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_occ   <= w_occ;
                    r_s1_ghost <= bus.ghost;
                    r_s1_fill  <= COLOR_W'(bus.shape) + COLOR_W'(1);
                    r_s1_ox    <= bus.px[LOG_T-1:0];
                    r_s1_oy    <= bus.py[LOG_T-1:0];
                end
            end
            if (w_s2_open) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_color  <= w_color;
                    r_opaque <= w_opaque;
                end
            end
            if (w_accept && (bus.shape == 3'd7)) begin
                err <= 1'b1;
            end
            if (r_s2_valid && bus.out_ready) begin
                pix_count <= pix_count + 16'd1;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.color     = r_color;
    assign bus.opaque    = r_opaque;

endmodule
`default_nettype wire

// File: doc/sprite_pixel_gen.md
SPRITE_PIXEL_GEN -- requirements
Module: sprite_pixel_gen

Interface
REQ-001 Parameter TILE, default 16: pixel edge of one block cell; power of two, at least 4.
REQ-002 Parameter BORDER, default 2: border thickness in pixels, applied to each cell edge; BORDER < TILE/2.
REQ-003 Parameter COLOR_W, default 3: width of the palette index.
REQ-004 Parameter BORDER_COLOR, default 7: palette index drawn on cell borders in normal mode.
REQ-005 Parameter GHOST_COLOR, default 6: palette index drawn on cell borders in ghost mode.
REQ-006 Parameter CW = $clog2(4*TILE): width of each pixel coordinate (6 at default).
REQ-007 Clk  in  1  single clock; all state updates on its rising edge.
REQ-008 Reset_n  in  1  reset, asynchronous and active-low.
REQ-009 in_valid  in  1  request present.
REQ-010 in_ready  out  1  request accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-011 shape  in  3  0=I 1=O 2=T 3=S 4=Z 5=J 6=L; 7 is invalid.
REQ-012 rot  in  2  number of clockwise quarter turns, 0..3.
REQ-013 ghost  in  1  1 = outline-only rendering.
REQ-014 px, py  in  CW each  pixel position inside the 4x4-cell bounding box; (0,0) is top-left.
REQ-015 out_valid  out  1  result present.
REQ-016 out_ready  in  1  result consumed when out_valid and out_ready are both 1 on a rising edge.
REQ-017 color  out  COLOR_W  palette index; 0 when opaque=0.
REQ-018 opaque  out  1  1 = pixel belongs to the sprite.
REQ-019 err  out  1  sticky; set when an invalid shape is accepted.
REQ-020 pix_count  out  16  count of completed output transfers.

Function
REQ-021 Each rotation-0 mask is a 16-bit value, bit index r*4+c, with row 0 at the top: I=0x00F0, O=0x0066, T=0x0072, S=0x0036, Z=0x0063, J=0x0071, L=0x0074.
REQ-022 Rotation k+1 is derived from rotation k by the rule new[r][c] = old[3-c][r]; rotations are computed from this rule, not stored as separate masks.
REQ-023 Cell and in-cell offset: row = py/TILE, col = px/TILE, oy = py mod TILE, ox = px mod TILE.
REQ-024 A pixel is border when any of ox, oy is < BORDER or >= TILE-BORDER; otherwise it is interior.
REQ-025 Cell not occupied, or shape=7: opaque=0, color=0.
REQ-026 Occupied cell, normal mode: border pixel gives BORDER_COLOR; interior pixel gives shape+1.
REQ-027 Occupied cell, ghost mode: border pixel gives GHOST_COLOR; interior pixel gives opaque=0, color=0.
REQ-028 Two-stage pipeline: stage 1 registers the mask lookup and offsets; stage 2 registers color and opaque. Latency from acceptance to out_valid is 2 cycles with no stall.
REQ-029 Throughput is one result per cycle while out_ready=1.
REQ-030 Backpressure: when out_valid=1 and out_ready=0, stage 2 holds and its outputs stay stable.
REQ-031 During that stall, stage 1 accepts only if it is empty.
REQ-032 in_ready = !s1_valid | !s2_valid | out_ready.
REQ-033 Stages advance independently; no bubble is inserted when both are full and out_ready=1.
REQ-034 pix_count increments by 1 on each output transfer and wraps from 0xFFFF to 0.
REQ-035 err sets on acceptance of shape=7 and stays set until reset; the request still produces a transparent result.
REQ-036 Simultaneous accept and output transfer in one cycle is legal and loses no data.

Reset
REQ-037 While Reset_n=0, asynchronously: s1_valid=0, s2_valid=0, out_valid=0, color=0, opaque=0, err=0, pix_count=0.
REQ-038 Reset mid-operation discards all in-flight requests with no output transfer.
REQ-039 in_ready reads 1 in the first cycle after Reset_n deasserts.

Verification
REQ-040 I, rot 0, normal mode, px=20 py=20, out_ready=1 -> 2 cycles later out_valid=1, color=1, opaque=1.
REQ-041 I, rot 0, px=20: py=17 gives color=7, opaque=1; py=5 gives opaque=0, color=0.
REQ-042 I, rot 1, px=40 py=5 -> color=1, opaque=1; same request in ghost mode -> opaque=0; ghost at px=33 py=5 -> color=6, opaque=1.
REQ-043 Stream 4 back-to-back requests, hold out_ready=0 for 3 cycles, then release -> all 4 results delivered in order, outputs stable while stalled, pix_count=4.
REQ-044 shape=7 accepted -> color=0, opaque=0, err=1 and still 1 after 10 further valid requests; Reset_n pulsed low -> err=0.
REQ-045 Reset_n asserted while 2 requests are in flight -> out_valid=0 immediately, pix_count=0, no stale result after release.
